// File: rtl/fft2d_corner_turn_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fft2d_corner_turn_ctrl_pkg
//   Shared types and helpers for the 2D FFT corner-turn controller.
//
//   Widths normally come from 00defines.v (`FFT_DATA_WIDTH,
//   `FFT2D_C_RAM_ADD_BITS, `RAM_ADD_WIDTH). The guarded fallbacks below only
//   apply when that file is not part of the compile, so a standalone build of
//   this slice still elaborates. They never override a real definition.
//
//   Contents:
//     xp_state_e  controller state encoding (XP_WRITE, XP_READ, XP_FLUSH)
//     SKID_DEPTH  depth of the output skid FIFO
//     can_issue   read-issue admission rule for the skid/inflight budget
// ----------------------------------------------------------------------------
`ifndef FFT_DATA_WIDTH
`define FFT_DATA_WIDTH 16
`endif
`ifndef FFT2D_C_RAM_ADD_BITS
`define FFT2D_C_RAM_ADD_BITS 2
`endif
`ifndef RAM_ADD_WIDTH
`define RAM_ADD_WIDTH 2
`endif

package fft2d_corner_turn_ctrl_pkg;

  // WRITE is the reset state; there is deliberately no idle state.
  typedef enum logic [1:0] {
    XP_WRITE = 2'd0,
    XP_READ  = 2'd1,
    XP_FLUSH = 2'd2
  } xp_state_e;

  localparam int SKID_DEPTH = 2;

  // A read may be issued when every sample already owed to the skid (stored
  // entries plus the one in flight from the RAM) still leaves room after this
  // cycle's pop. Evaluated as occ + inflight < 2 + pop to stay unsigned.
  function automatic logic can_issue(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] owed;
    logic [2:0] room;
    owed = {1'b0, occ} + {2'b00, inflight};
    room = 3'(SKID_DEPTH) + {2'b00, pop};
    return owed < room;
  endfunction

endpackage

// File: rtl/fft2d_skid_fifo2.sv
// ----------------------------------------------------------------------------
// fft2d_skid_fifo2
//   Two-entry FIFO that decouples the registered RAM read path from the
//   column-FFT ready signal. The head entry is presented combinationally.
//
//   Ports:
//     clk        clock, posedge
//     rst        synchronous active-high reset (empties the FIFO)
//     push       write push_data at the tail (caller guarantees not full)
//     push_data  W-bit entry
//     pop        drop the head entry (caller guarantees not empty)
//     head_data  current head entry (undefined while empty)
//     occ        number of stored entries, 0..2
// ----------------------------------------------------------------------------
module fft2d_skid_fifo2
  import fft2d_corner_turn_ctrl_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   occ
);

  logic [W-1:0] mem_q [SKID_DEPTH];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    occ_d    = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + 2'd1;
    end else if (pop && !push) begin
      occ_d = occ_q - 2'd1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // NOTE: the storage array has no reset; occ_q alone decides validity, and
  // leaving data flops unreset keeps them plain enable-flops.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign occ       = occ_q;

endmodule

// File: rtl/fft2d_corner_turn_ctrl.sv
// ----------------------------------------------------------------------------
// fft2d_corner_turn_ctrl
//   Corner-turn (transpose) controller between the row-FFT and column-FFT
//   stages. One frame of row-FFT output is written row-major into the
//   dual-port FFT2D_RAM via port 0, then read back column-major via port 1
//   and streamed to the column FFT through a 2-entry skid FIFO.
//
//   Parameters:
//     DW  sample width                     (`FFT_DATA_WIDTH)
//     RB  log2(rows per frame), addr MSBs  (`FFT2D_C_RAM_ADD_BITS)
//     CB  log2(samples per row), addr LSBs (`RAM_ADD_WIDTH)
//
//   Ports:
//     clk, rst                 posedge clock, synchronous active-high reset
//     in_valid/in_ready/in_data     row-FFT input stream
//     out_valid/out_ready/out_data  column-ordered output stream
//     out_last                 head sample is the last row of its column
//     frame_done               1-cycle pulse on the final output handshake
//     address_0, data_0        RAM port 0 (write); data_0 driven only when we_0
//     cs_0, we_0, oe_0         RAM port 0 controls; oe_0 tied low
//     address_1, data_1        RAM port 1 (read); data_1 never driven here
//     cs_1, we_1, oe_1         RAM port 1 controls; we_1 tied low
//     ovf_err                  (FFT2D_CORNER_TURN_ERR_EN only) sticky flag,
//                              set by in_valid while in_ready is low
//
//   Configuration macro: FFT2D_CORNER_TURN_ERR_EN adds the ovf_err output.
//   Without it, in_valid during READ/FLUSH is simply stalled.
// ----------------------------------------------------------------------------
module fft2d_corner_turn_ctrl
  import fft2d_corner_turn_ctrl_pkg::*;
#(
  parameter int DW = `FFT_DATA_WIDTH,
  parameter int RB = `FFT2D_C_RAM_ADD_BITS,
  parameter int CB = `RAM_ADD_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       out_data,
  output logic                out_last,
  output logic                frame_done,
  output logic [RB+CB-1:0]    address_0,
  inout  wire  [DW-1:0]       data_0,
  output logic                cs_0,
  output logic                we_0,
  output logic                oe_0,
  output logic [RB+CB-1:0]    address_1,
  inout  wire  [DW-1:0]       data_1,
  output logic                cs_1,
  output logic                we_1,
  output logic                oe_1
`ifdef FFT2D_CORNER_TURN_ERR_EN
  ,
  output logic                ovf_err
`endif
);

  localparam int AW = RB + CB;

  xp_state_e     state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;   // {row, col}, col fastest
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;   // {col, row}, row fastest
  logic          inflight_q, inflight_d;
  logic          inflight_last_q, inflight_last_d;
  logic          in_ready_q, in_ready_d;
  logic          rd_en_q, rd_en_d;

  logic          wr_fire;
  logic          rd_issue;
  logic          pop;
  logic          skid_push;
  logic [1:0]    skid_occ;
  logic [DW:0]   skid_head;
  logic [RB-1:0] rd_r;
  logic [CB-1:0] rd_c;

  // The read pointer counts with the row in its low bits so that walking it
  // linearly visits every row of a column before moving to the next column.
  assign rd_r = rd_ptr_q[RB-1:0];
  assign rd_c = rd_ptr_q[AW-1:RB];

  // RAM strobes are masked by rst so that no access happens in a reset cycle,
  // even when a frame is abandoned midway.
  assign wr_fire   = in_valid & in_ready_q & ~rst;
  assign out_valid = (skid_occ != 2'd0);
  assign pop       = out_valid & out_ready & ~rst;
  assign rd_issue  = (state_q == XP_READ) & can_issue(skid_occ, inflight_q, pop) & ~rst;
  // The RAM registers the issued address; its data is on data_1 one cycle
  // later, which is exactly when inflight_q is high.
  assign skid_push = inflight_q & ~rst;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    inflight_d      = rd_issue;
    inflight_last_d = rd_issue & (rd_r == {RB{1'b1}});

    case (state_q)
      XP_WRITE: begin
        if (wr_fire) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          // Last cell written this cycle; reading starts next cycle.
          if (wr_ptr_q == {AW{1'b1}}) begin
            state_d = XP_READ;
          end
        end
      end
      XP_READ: begin
        if (rd_issue) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          if (rd_ptr_q == {AW{1'b1}}) begin
            state_d = XP_FLUSH;
          end
        end
      end
      XP_FLUSH: begin
        // Every issued read has landed and been consumed.
        if ((skid_occ == 2'd0) && !inflight_q) begin
          state_d  = XP_WRITE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
        end
      end
      default: begin
        state_d = XP_WRITE;
      end
    endcase

    // Registered strobes follow the next state so they change with it.
    in_ready_d = (state_d == XP_WRITE);
    rd_en_d    = (state_d != XP_WRITE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= XP_WRITE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      in_ready_q      <= 1'b1;
      rd_en_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      in_ready_q      <= in_ready_d;
      rd_en_q         <= rd_en_d;
    end
  end

  // The last-of-column flag travels with its sample through the skid.
  fft2d_skid_fifo2 #(
    .W (DW + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (skid_push),
    .push_data ({inflight_last_q, data_1}),
    .pop       (pop),
    .head_data (skid_head),
    .occ       (skid_occ)
  );

  assign out_data = skid_head[DW-1:0];
  assign out_last = out_valid & skid_head[DW];

  // In FLUSH with nothing in flight, a single stored entry is the frame's
  // final sample. FLUSH never coincides with in_ready, so neither does this.
  assign frame_done = pop & (state_q == XP_FLUSH) & ~inflight_q & (skid_occ == 2'd1);

  assign in_ready  = in_ready_q;

  assign address_0 = wr_ptr_q;
  assign cs_0      = wr_fire;
  assign we_0      = wr_fire;
  assign oe_0      = 1'b0;
  assign data_0    = we_0 ? in_data : {DW{1'bz}};

  assign address_1 = {rd_r, rd_c};
  assign cs_1      = rd_en_q & ~rst;
  assign oe_1      = rd_en_q & ~rst;
  assign we_1      = 1'b0;

`ifdef FFT2D_CORNER_TURN_ERR_EN
  logic ovf_err_q, ovf_err_d;

  always_comb begin
    ovf_err_d = ovf_err_q | (in_valid & ~in_ready_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
    end
  end

  assign ovf_err = ovf_err_q;
`endif

endmodule

// File: tb/tb_fft2d_corner_turn_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fft2d_corner_turn_ctrl
//   Directed bench for the corner-turn controller on a 4x4 frame with a
//   behavioural dual-port RAM (write port 0, registered read port 1 gated by
//   cs_1/oe_1). Inputs change 1 time unit after posedge; outputs are sampled
//   on the negedge.
// ----------------------------------------------------------------------------
module tb_fft2d_corner_turn_ctrl;

  localparam int DW = 16;
  localparam int RB = 2;
  localparam int CB = 2;
  localparam int AW = RB + CB;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          frame_done;
  logic [AW-1:0] address_0, address_1;
  wire  [DW-1:0] data_0, data_1;
  logic          cs_0, we_0, oe_0, cs_1, we_1, oe_1;
`ifdef FFT2D_CORNER_TURN_ERR_EN
  logic          ovf_err;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int wr_count = 0;

  logic [DW-1:0] ram [N];
  logic [DW-1:0] ram_rd_q;
  logic [DW-1:0] zz;

  always #5 clk = ~clk;

  fft2d_corner_turn_ctrl #(.DW(DW), .RB(RB), .CB(CB)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done),
    .address_0  (address_0),
    .data_0     (data_0),
    .cs_0       (cs_0),
    .we_0       (we_0),
    .oe_0       (oe_0),
    .address_1  (address_1),
    .data_1     (data_1),
    .cs_1       (cs_1),
    .we_1       (we_1),
    .oe_1       (oe_1)
`ifdef FFT2D_CORNER_TURN_ERR_EN
    ,
    .ovf_err    (ovf_err)
`endif
  );

  // Behavioural FFT2D_RAM: write on port 0, registered read on port 1 whose
  // output is only visible while cs_1/oe_1 are still high.
  always @(posedge clk) begin
    if (cs_0 && we_0) begin
      ram[address_0] <= data_0;
      wr_count       <= wr_count + 1;
    end
    if (cs_1 && oe_1 && !we_1) begin
      ram_rd_q <= ram[address_1];
    end
  end
  assign data_1 = (cs_1 && oe_1) ? ram_rd_q : {DW{1'bz}};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Writes base..base+15. gap=0: back-to-back; gap=k: in_valid 1 cycle in k.
  task automatic write_frame(input int base, input int gap);
    int i  = 0;
    int t  = 0;
    int w0 = wr_count;
    while (i < N && t < 400) begin
      in_valid = (gap == 0) || (t % gap == 0);
      in_data  = DW'(base + i);
      @(negedge clk);
      if (in_valid && in_ready) begin
        if (i == 0) check("wr_data_0_driven", data_0, in_data);
        i++;
      end
      cyc();
      t++;
    end
    in_valid = 1'b0;
    check("wr_accepted", i, N);
    @(negedge clk);
    check("in_ready_after_last_write", in_ready, 1'b0);
    check("cs_1_in_read", cs_1, 1'b1);
    check("oe_1_in_read", oe_1, 1'b1);
    check("we_1_tied", we_1, 1'b0);
    check("oe_0_tied", oe_0, 1'b0);
    check("data_0_released", data_0, zz);
    check("write_count", wr_count - w0, N);
    cyc();
  endtask

  // Collects n_out samples in column-major order from base.
  task automatic read_frame(input int base, input int n_out, input bit rand_rdy, input bit junk);
    int            i       = 0;
    int            t       = 0;
    int            first_t = -1;
    int            last_t  = 0;
    int            w0      = wr_count;
    logic          stalled = 1'b0;
    logic [DW-1:0] held    = '0;
    logic [DW-1:0] exp;
    while (i < n_out && t < 1000) begin
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = junk && (i < 8);
      in_data   = 16'hdead;
      @(negedge clk);
      if (stalled) begin
        check("stall_valid_held", out_valid, 1'b1);
        check("stall_data_held", out_data, held);
      end
      if (out_valid && out_ready) begin
        exp = DW'(base + (i % 4) * 4 + i / 4);
        check("out_data", out_data, exp);
        check("out_last", out_last, (i % 4) == 3);
        check("frame_done", frame_done, i == N - 1);
        if (i == N - 1) check("in_ready_at_done", in_ready, 1'b0);
        if (first_t < 0) first_t = t;
        last_t  = t;
        stalled = 1'b0;
        i++;
      end else begin
        check("frame_done_idle", frame_done, 1'b0);
        stalled = out_valid;
        held    = out_data;
      end
      if (junk) check("no_write_in_read", cs_0, 1'b0);
      cyc();
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("rd_collected", i, n_out);
    if (junk) check("junk_not_written", wr_count - w0, 0);
    if (n_out == N) begin
      if (!rand_rdy) check("one_per_clk", last_t - first_t, N - 1);
      @(negedge clk);
      check("in_ready_after_done", in_ready, 1'b0);
      cyc();
      @(negedge clk);
      check("in_ready_back", in_ready, 1'b1);
      check("cs_1_idle", cs_1, 1'b0);
      check("out_valid_idle", out_valid, 1'b0);
      check("address_0_wrapped", address_0, 0);
      check("address_1_wrapped", address_1, 0);
      cyc();
    end
  endtask

  initial begin
    zz = {DW{1'bz}};

    // Reset: in_valid high must not reach the RAM.
    in_valid = 1'b1;
    in_data  = 16'h1234;
    @(negedge clk);
    check("rst_no_cs_0", cs_0, 1'b0);
    check("rst_no_we_0", we_0, 1'b0);
    cyc();
    in_valid = 1'b0;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_last", out_last, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_cs_1", cs_1, 1'b0);
    check("reset_oe_1", oe_1, 1'b0);
    check("reset_address_0", address_0, 0);
    check("reset_address_1", address_1, 0);
`ifdef FFT2D_CORNER_TURN_ERR_EN
    check("reset_ovf_err", ovf_err, 1'b0);
`endif
    cyc();

    // 1: back-to-back frame, always ready.
    write_frame(0, 0);
    read_frame(0, N, 1'b0, 1'b0);

    // 2: random out_ready.
    write_frame(0, 0);
    read_frame(0, N, 1'b1, 1'b0);

    // 3: gapped input, one valid in three cycles.
    write_frame(0, 3);
    read_frame(0, N, 1'b0, 1'b0);

    // 4: two frames back-to-back, the second from 100.
    write_frame(0, 0);
    read_frame(0, N, 1'b0, 1'b0);
    write_frame(100, 0);
    read_frame(100, N, 1'b0, 1'b0);

    // 5: reset after 6 outputs, then a fresh frame.
    write_frame(50, 0);
    read_frame(50, 6, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_no_cs_0", cs_0, 1'b0);
    check("midrst_no_cs_1", cs_1, 1'b0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("postrst_out_valid", out_valid, 1'b0);
    check("postrst_in_ready", in_ready, 1'b1);
    check("postrst_cs_0", cs_0, 1'b0);
    check("postrst_cs_1", cs_1, 1'b0);
    check("postrst_address_1", address_1, 0);
    cyc();
    write_frame(0, 0);
    read_frame(0, N, 1'b0, 1'b0);
`ifdef FFT2D_CORNER_TURN_ERR_EN
    check("ovf_err_clean", ovf_err, 1'b0);
`endif

    // 6: in_valid during READ is stalled (and flagged when enabled).
    write_frame(0, 0);
    read_frame(0, N, 1'b0, 1'b1);
`ifdef FFT2D_CORNER_TURN_ERR_EN
    @(negedge clk);
    check("ovf_err_sticky", ovf_err, 1'b1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("ovf_err_cleared", ovf_err, 1'b0);
    cyc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
